// File: rtl/ifid_fetch_stage_if.sv
// Front-end bus between the fetch stage and its neighbours: hazard controls,
// branch redirect, instruction memory and the IF/ID latch outputs. IFID_STALL_COUNT_EN adds counters.
interface ifid_fetch_stage_if;
    logic        pc_write_en;
    logic        ifid_write_en;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] instr_in;
    logic [15:0] pc_out;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic        halted;
`ifdef IFID_STALL_COUNT_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;

    modport master (
        input  pc_write_en, ifid_write_en, branch_taken, branch_target, instr_in,
        output pc_out, ifid_instr, ifid_pc_plus2, ifid_valid, halted,
        output stall_cycles, flush_count
    );

    modport slave (
        output pc_write_en, ifid_write_en, branch_taken, branch_target, instr_in,
        input  pc_out, ifid_instr, ifid_pc_plus2, ifid_valid, halted,
        input  stall_cycles, flush_count
    );
`else
    modport master (
        input  pc_write_en, ifid_write_en, branch_taken, branch_target, instr_in,
        output pc_out, ifid_instr, ifid_pc_plus2, ifid_valid, halted
    );

    modport slave (
        output pc_write_en, ifid_write_en, branch_taken, branch_target, instr_in,
        input  pc_out, ifid_instr, ifid_pc_plus2, ifid_valid, halted
    );
`endif
endinterface

// File: rtl/ifid_fetch_stage.sv
// PC register and IF/ID latch with stall, branch flush and HLT freeze.
// Optional IFID_STALL_COUNT_EN adds saturating stall_cycles / flush_count counters.
module ifid_fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'b1111
) (
    input logic                 clk,
    input logic                 rst_n,
    ifid_fetch_stage_if.master  fe
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic [15:0] pc_plus2;
    logic [15:0] instr_q;
    logic [15:0] instr_d;
    logic [15:0] pp2_q;
    logic [15:0] pp2_d;
    logic        valid_q;
    logic        valid_d;
    logic        halted_q;
    logic        fetch_is_hlt;
    logic        held_is_hlt;

    assign pc_plus2     = pc_q + 16'd2;
    assign fetch_is_hlt = (fe.instr_in[15:12] == HLT_OPCODE);
    assign held_is_hlt  = valid_q && (instr_q[15:12] == HLT_OPCODE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (fe.branch_taken) begin
                    state_nxt = RUN;
                end else if (fe.pc_write_en && fetch_is_hlt) begin
                    state_nxt = HALT_PEND;
                end
            end
            HALT_PEND: begin
                if (fe.branch_taken) begin
                    state_nxt = RUN;
                end else if (fe.ifid_write_en && held_is_hlt) begin
                    state_nxt = HALTED;
                end
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    // Next-value logic for the PC and IF/ID latch; a flush always beats a stall.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pp2_d   = pp2_q;
        valid_d = valid_q;
        case (state)
            RUN: begin
                if (fe.branch_taken) begin
                    pc_d    = fe.branch_target;
                    instr_d = 16'h0000;
                    valid_d = 1'b0;
                end else begin
                    if (fe.pc_write_en && !fetch_is_hlt) begin
                        pc_d = pc_plus2;
                    end
                    if (fe.ifid_write_en) begin
                        instr_d = fe.instr_in;
                        pp2_d   = pc_plus2;
                        valid_d = 1'b1;
                    end
                end
            end
            HALT_PEND: begin
                if (fe.branch_taken) begin
                    pc_d    = fe.branch_target;
                    instr_d = 16'h0000;
                    valid_d = 1'b0;
                end else if (fe.ifid_write_en && held_is_hlt) begin
                    instr_d = 16'h0000;
                    valid_d = 1'b0;
                end else if (fe.ifid_write_en) begin
                    instr_d = fe.instr_in;
                    pp2_d   = pc_plus2;
                    valid_d = 1'b1;
                end
            end
            HALTED: begin
                instr_d = 16'h0000;
                valid_d = 1'b0;
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            instr_q  <= 16'h0000;
            pp2_q    <= 16'h0000;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pp2_q    <= pp2_d;
            valid_q  <= valid_d;
            halted_q <= (state_nxt == HALTED);
        end
    end

    assign fe.pc_out        = pc_q;
    assign fe.ifid_instr    = instr_q;
    assign fe.ifid_pc_plus2 = pp2_q;
    assign fe.ifid_valid    = valid_q;
    assign fe.halted        = halted_q;

`ifdef IFID_STALL_COUNT_EN
    logic [15:0] stall_q;
    logic [15:0] flush_q;
    logic        branch_acted;

    // Only branches that actually redirect count; HALTED ignores them.
    assign branch_acted = fe.branch_taken && (state != HALTED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= 16'h0000;
            flush_q <= 16'h0000;
        end else begin
            if ((state == RUN) && !fe.branch_taken && !fe.pc_write_en && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
            if (branch_acted && (flush_q != 16'hFFFF)) begin
                flush_q <= flush_q + 16'd1;
            end
        end
    end

    assign fe.stall_cycles = stall_q;
    assign fe.flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_ifid_fetch_stage.sv
// Self-checking bench for ifid_fetch_stage: directed scenarios plus randomized
// traffic compared against a flag-based behavioural model.
module tb_ifid_fetch_stage;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    ifid_fetch_stage_if bus ();

    ifid_fetch_stage #(
        .RESET_PC  (16'h0000),
        .HLT_OPCODE(4'b1111)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .fe   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: pending/halted flags instead of a state machine.
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_pp2;
    logic        m_valid;
    logic        m_pend;
    logic        m_halted;

    task automatic model_step();
        logic [15:0] next_seq;
        next_seq = m_pc + 16'd2;
        if (!rst_n) begin
            m_pc = 16'h0000; m_instr = 16'h0000; m_pp2 = 16'h0000;
            m_valid = 1'b0; m_pend = 1'b0; m_halted = 1'b0;
        end else if (m_halted) begin
            m_valid = 1'b0; m_instr = 16'h0000;
        end else if (bus.branch_taken) begin
            m_pc = bus.branch_target; m_valid = 1'b0; m_instr = 16'h0000; m_pend = 1'b0;
        end else if (m_pend) begin
            if (bus.ifid_write_en) begin
                if (m_valid && m_instr[15:12] == 4'hF) begin
                    m_valid = 1'b0; m_instr = 16'h0000; m_pend = 1'b0; m_halted = 1'b1;
                end else begin
                    m_instr = bus.instr_in; m_pp2 = next_seq; m_valid = 1'b1;
                end
            end
        end else begin
            if (bus.ifid_write_en) begin
                m_instr = bus.instr_in; m_pp2 = next_seq; m_valid = 1'b1;
            end
            if (bus.pc_write_en) begin
                if (bus.instr_in[15:12] == 4'hF) m_pend = 1'b1;
                else m_pc = next_seq;
            end
        end
    endtask

    task automatic step(input logic rn, input logic pwe, input logic iwe, input logic br,
                        input logic [15:0] tgt, input logic [15:0] instr);
        rst_n             = rn;
        bus.pc_write_en   = pwe;
        bus.ifid_write_en = iwe;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        bus.instr_in      = instr;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h5555);
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0ABC, 16'hF000);
        checks++; if (bus.pc_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pc actual=%h required=%h", bus.pc_out, 16'h0000); end
        checks++; if (bus.ifid_instr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_instr actual=%h required=%h", bus.ifid_instr, 16'h0000); end
        checks++; if (bus.ifid_pc_plus2 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pp2 actual=%h required=%h", bus.ifid_pc_plus2, 16'h0000); end
        checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid actual=%b required=0", bus.ifid_valid); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted actual=%b required=0", bus.halted); end
    endtask

    task automatic test_free_run();
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234);
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234);
            checks++; if (bus.pc_out !== 16'(2 * k)) begin errors++; $display("[TB] FAIL run_pc[%0d] actual=%h required=%h", k, bus.pc_out, 16'(2 * k)); end
            checks++; if (bus.ifid_pc_plus2 !== 16'(2 * k)) begin errors++; $display("[TB] FAIL run_pp2[%0d] actual=%h required=%h", k, bus.ifid_pc_plus2, 16'(2 * k)); end
            checks++; if (bus.ifid_valid !== 1'b1 || bus.ifid_instr !== 16'h1234) begin errors++; $display("[TB] FAIL run_ifid[%0d] actual=%b/%h required=1/1234", k, bus.ifid_valid, bus.ifid_instr); end
        end
    endtask

    task automatic test_stall();
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234);
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234);
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h7777);
            checks++; if (bus.pc_out !== 16'h0004) begin errors++; $display("[TB] FAIL stall_pc[%0d] actual=%h required=0004", k, bus.pc_out); end
            checks++; if (bus.ifid_instr !== 16'h1234 || bus.ifid_pc_plus2 !== 16'h0004) begin errors++; $display("[TB] FAIL stall_ifid[%0d] actual=%h/%h required=1234/0004", k, bus.ifid_instr, bus.ifid_pc_plus2); end
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h7777);
        checks++; if (bus.pc_out !== 16'h0006 || bus.ifid_pc_plus2 !== 16'h0006 || bus.ifid_instr !== 16'h7777) begin errors++; $display("[TB] FAIL stall_resume actual=%h/%h/%h required=0006/0006/7777", bus.pc_out, bus.ifid_pc_plus2, bus.ifid_instr); end
    endtask

    task automatic test_flush_over_stall();
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234);
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0010, 16'h1234);
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h2222);
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0040, 16'h3333);
        checks++; if (bus.pc_out !== 16'h0040) begin errors++; $display("[TB] FAIL flush_pc actual=%h required=0040", bus.pc_out); end
        checks++; if (bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 16'h0000) begin errors++; $display("[TB] FAIL flush_ifid actual=%b/%h required=0/0000", bus.ifid_valid, bus.ifid_instr); end
    endtask

    task automatic test_wrap();
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFE, 16'h1234);
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h4321);
        checks++; if (bus.pc_out !== 16'h0000 || bus.ifid_pc_plus2 !== 16'h0000) begin errors++; $display("[TB] FAIL wrap actual=%h/%h required=0000/0000", bus.pc_out, bus.ifid_pc_plus2); end
        checks++; if (bus.ifid_valid !== 1'b1 || bus.ifid_instr !== 16'h4321) begin errors++; $display("[TB] FAIL wrap_ifid actual=%b/%h required=1/4321", bus.ifid_valid, bus.ifid_instr); end
    endtask

    task automatic test_halt();
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234);
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0008, 16'h1234);
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hF000);
        checks++; if (bus.pc_out !== 16'h0008 || bus.ifid_instr !== 16'hF000 || bus.ifid_valid !== 1'b1) begin errors++; $display("[TB] FAIL halt_fetch actual=%h/%h/%b required=0008/f000/1", bus.pc_out, bus.ifid_instr, bus.ifid_valid); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_early actual=%b required=0", bus.halted); end
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hF000);
        checks++; if (bus.halted !== 1'b1 || bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 16'h0000 || bus.pc_out !== 16'h0008) begin errors++; $display("[TB] FAIL halt_enter actual=%b/%b/%h/%h required=1/0/0000/0008", bus.halted, bus.ifid_valid, bus.ifid_instr, bus.pc_out); end
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0020, 16'h1234);
        checks++; if (bus.halted !== 1'b1 || bus.pc_out !== 16'h0008 || bus.ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_ignore_branch actual=%b/%h/%b required=1/0008/0", bus.halted, bus.pc_out, bus.ifid_valid); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234);
        checks++; if (bus.halted !== 1'b0 || bus.pc_out !== 16'h0000) begin errors++; $display("[TB] FAIL halt_reset actual=%b/%h required=0/0000", bus.halted, bus.pc_out); end
    endtask

    task automatic test_halt_squash();
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0008, 16'h1234);
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hF000);
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0020, 16'hF000);
        checks++; if (bus.pc_out !== 16'h0020 || bus.halted !== 1'b0 || bus.ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL squash actual=%h/%b/%b required=0020/0/0", bus.pc_out, bus.halted, bus.ifid_valid); end
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234);
        checks++; if (bus.pc_out !== 16'h0022 || bus.ifid_valid !== 1'b1 || bus.halted !== 1'b0) begin errors++; $display("[TB] FAIL squash_run actual=%h/%b/%b required=0022/1/0", bus.pc_out, bus.ifid_valid, bus.halted); end
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0100, 16'hF000);
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234);
        checks++; if (bus.pc_out !== 16'h0102 || bus.halted !== 1'b0) begin errors++; $display("[TB] FAIL hlt_vs_branch actual=%h/%b required=0102/0", bus.pc_out, bus.halted); end
    endtask

    task automatic test_random();
        logic rn;
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
        for (int k = 0; k < 600; k++) begin
            rn = ($urandom_range(0, 59) != 0) && !(m_halted && $urandom_range(0, 3) == 0);
            step(rn, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 7) == 0), 16'($urandom), 16'($urandom));
            checks++; if (bus.pc_out !== m_pc) begin errors++; $display("[TB] FAIL rand_pc[%0d] actual=%h required=%h", k, bus.pc_out, m_pc); end
            checks++; if (bus.ifid_instr !== m_instr) begin errors++; $display("[TB] FAIL rand_instr[%0d] actual=%h required=%h", k, bus.ifid_instr, m_instr); end
            checks++; if (bus.ifid_pc_plus2 !== m_pp2) begin errors++; $display("[TB] FAIL rand_pp2[%0d] actual=%h required=%h", k, bus.ifid_pc_plus2, m_pp2); end
            checks++; if (bus.ifid_valid !== m_valid) begin errors++; $display("[TB] FAIL rand_valid[%0d] actual=%b required=%b", k, bus.ifid_valid, m_valid); end
            checks++; if (bus.halted !== m_halted) begin errors++; $display("[TB] FAIL rand_halted[%0d] actual=%b required=%b", k, bus.halted, m_halted); end
        end
    endtask

`ifdef IFID_STALL_COUNT_EN
    task automatic test_counters();
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1234);
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0030, 16'h1234);
        checks++; if (bus.stall_cycles !== 16'd3 || bus.flush_count !== 16'd1) begin errors++; $display("[TB] FAIL counters actual=%0d/%0d required=3/1", bus.stall_cycles, bus.flush_count); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234);
        checks++; if (bus.stall_cycles !== 16'd0 || bus.flush_count !== 16'd0) begin errors++; $display("[TB] FAIL counters_reset actual=%0d/%0d required=0/0", bus.stall_cycles, bus.flush_count); end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.pc_write_en = 1'b0;
        bus.ifid_write_en = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = 16'h0000;
        bus.instr_in = 16'h0000;
        m_pc = 16'h0000; m_instr = 16'h0000; m_pp2 = 16'h0000;
        m_valid = 1'b0; m_pend = 1'b0; m_halted = 1'b0;
        test_reset();
        test_free_run();
        test_stall();
        test_flush_over_stall();
        test_wrap();
        test_halt();
        test_halt_squash();
        test_random();
`ifdef IFID_STALL_COUNT_EN
        test_counters();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifid_fetch_stage.md
Name: ifid_fetch_stage

Overview:
- Consumes the stall controls produced by hazard detection: the PC register and IF/ID pipeline latch that obey PC/IF-ID write enables.
- Applies branch redirect/flush from the ID-stage branch resolution.
- Tracks HLT (opcode 4'b1111) through fetch so the front end freezes cleanly.
- Sits between instruction memory (combinational read of pc_out) and the ID stage.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HLT_OPCODE, 4'b1111, opcode treated as halt.

Ports:
- clk  input  1  pipeline clock
- rst_n  input  1  synchronous active-low reset
- pc_write_en  input  1  1 = PC may update; 0 = hold (stall)
- ifid_write_en  input  1  1 = IF/ID may latch; 0 = hold (stall)
- branch_taken  input  1  ID-stage branch resolved taken; flush request
- branch_target  input  16  redirect address
- instr_in  input  16  imem data for pc_out, same cycle
- pc_out  output  16  current fetch PC to imem
- ifid_instr  output  16  latched instruction to ID
- ifid_pc_plus2  output  16  latched PC+2 of that instruction
- ifid_valid  output  1  IF/ID holds a real instruction
- halted  output  1  front end frozen after HLT

Behaviour:
- Reset, sampled on posedge clk with rst_n=0:
  - pc_out=RESET_PC.
  - ifid_instr=16'h0000, ifid_pc_plus2=16'h0000, ifid_valid=0.
  - halted=0, state=RUN.
- Reset overrides every other input.
- PC arithmetic: pc_plus2 = pc_out + 2, modulo 2^16. 16'hFFFE wraps to 16'h0000. No carry out.
- State machine: RUN, HALT_PEND, HALTED.
- RUN:
  - branch_taken=1 (highest priority, ignores both write enables): pc<=branch_target; ifid_valid<=0; ifid_instr<=0; stay RUN.
  - Else if pc_write_en=1 and instr_in[15:12]==HLT_OPCODE: pc holds (does not advance past HLT). IF/ID latches the HLT if ifid_write_en=1. Go to HALT_PEND.
  - Else if pc_write_en=1: pc<=pc_plus2.
  - Independently, if ifid_write_en=1: ifid_instr<=instr_in, ifid_pc_plus2<=pc_plus2, ifid_valid<=1.
  - If an enable is 0, the corresponding register holds its value exactly.
- HALT_PEND (HLT sits in IF/ID, or is waiting to enter it):
  - PC frozen regardless of pc_write_en.
  - branch_taken=1: an older branch squashes the HLT. pc<=branch_target, flush IF/ID, go to RUN.
  - Else if ifid_write_en=1 and ifid_valid=1 and ifid_instr[15:12]==HLT_OPCODE: HLT advances to ID. IF/ID loads a bubble (valid=0, instr=0). Go to HALTED.
  - Else if ifid_write_en=1 and IF/ID does not yet hold the HLT: latch instr_in (the HLT).
  - ifid_write_en=0: hold.
- HALTED:
  - halted=1 (registered, asserts the cycle after entry).
  - PC frozen. IF/ID forced to a bubble each cycle.
  - branch_taken ignored. Only reset exits.
- Simultaneous events:
  - branch_taken with pc_write_en=0 or ifid_write_en=0: the flush still takes effect (flush beats stall).
  - HLT fetched in the same cycle as branch_taken: the branch wins, no HALT_PEND.
- Reset mid-stall or mid-halt returns everything to reset values in one cycle.
- Latency: an instruction presented on instr_in appears on ifid_instr 1 cycle later when unstalled.

Optional Feature:
- Macro: IFID_STALL_COUNT_EN.
- Defined:
  - Adds output stall_cycles[15:0], reset to 0.
  - Increments (saturating at 16'hFFFF) on every cycle with rst_n=1, state=RUN, branch_taken=0 and pc_write_en=0.
  - Also adds output flush_count[15:0], saturating, incrementing on each taken branch.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
1. Reset then free run, instr_in=16'h1234 constant, enables=1 → pc_out 0,2,4,6; ifid_valid=1 from cycle 1; ifid_pc_plus2 2,4,6 lagging by one cycle.
2. Stall: at pc=16'h0004, drop pc_write_en and ifid_write_en for 2 cycles → pc_out stays 4 and ifid_instr/pc_plus2 unchanged for 2 cycles, then advance to 6.
3. Flush over stall: pc=16'h0010, branch_taken=1, target=16'h0040, both enables=0 → next cycle pc_out=16'h0040, ifid_valid=0, ifid_instr=0.
4. Wrap: load pc=16'hFFFE via branch, run → pc_out=16'h0000 next, ifid_pc_plus2=16'h0000.
5. Halt:
   - instr_in=16'hF000 at pc=8 → pc stays 8, ifid_instr=16'hF000; next cycle IF/ID becomes a bubble and halted=1.
   - branch_taken afterward → no change.
   - Variant: branch_taken during HALT_PEND, target=16'h0020 → RUN, pc=16'h0020, halted stays 0.
6. With IFID_STALL_COUNT_EN: 3 stall cycles then 1 taken branch → stall_cycles=3, flush_count=1. Reset mid-stall → both 0 next cycle.
